io_bus_ctrl: RTL
================

# io_bus_ctrl

Memory/IO controller directly downstream of the multi-cycle CPU's IO port. Turns each `io_mode`/`io_addr`/`io_wdata` request into a multi-cycle access to asynchronous 32-bit SRAM or to the UART registers, then returns load data with a one-cycle `io_ready` pulse. Performs byte/half-word lane selection, sign/zero extension and address decode, so the CPU sees one uniform word-addressed IO port.

## Interface
- `WAIT_CYCLES`, 2: cycles SRAM strobes are held per access; legal range 1..15.
- `RAM_BASE`, 32'h8000_0000: SRAM base address; window is 4 MiB, covering word addresses 0..2^20-1.
- `UART_DATA`, 32'hBFD0_03F8: UART data register address.
- `UART_STAT`, 32'hBFD0_03FC: UART status register address.

Ports (clock and reset first):
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `io_mode` in 4: request type. Encodings: NOP=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8; values 9..15 are treated as NOP.
- `io_addr` in 32: byte address.
- `io_wdata` in 32: store data, right-aligned.
- `io_rdata` out 32: registered load result, extended per mode.
- `io_ready` out 1: one-cycle completion pulse.
- `sram_addr` out 20: SRAM word address, equal to `io_addr[21:2]`.
- `sram_dout` out 32: write data driven toward the SRAM.
- `sram_din` in 32: read data from the SRAM.
- `sram_doe` out 1: enables the tristate driver for `sram_dout`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: SRAM strobes, active-low.
- `sram_be_n` out 4: byte enables, active-low; bit i selects bits 8i+7:8i.
- `uart_tx_data` out 8: byte to transmit.
- `uart_tx_valid` out 1: one-cycle transmit strobe.
- `uart_tx_busy` in 1: transmitter busy.
- `uart_rx_data` in 8: received byte.
- `uart_rx_valid` in 1: a received byte is pending.
- `uart_rx_ack` out 1: one-cycle pulse that pops the received byte.

## Operation
- States: IDLE, SRAM, UART_WAIT, RESP.
- IDLE: the controller samples `io_mode`. A non-NOP request is latched together with its address and data.
  - RAM hit, aligned → SRAM.
  - UART_DATA write → UART_WAIT.
  - Any other UART access → RESP.
  - Unmapped or misaligned → RESP with no side effects.
- Address map:
  - RAM hit: `io_addr[31:22]` equals `RAM_BASE[31:22]`.
  - UART access: exact address match on `UART_DATA` or `UART_STAT`.
- Alignment:
  - LW/SW require `addr[1:0]`=0.
  - LH/LHU/SH require `addr[0]`=0.
  - Misaligned access returns `io_rdata`=0.
- SRAM state, applies for exactly `WAIT_CYCLES` cycles:
  - `sram_ce_n`=0 throughout.
  - Reads: `sram_oe_n`=0 and `sram_be_n`=0000.
  - Writes: `sram_we_n`=0, `sram_doe`=1, and `sram_be_n` low only on the selected lanes.
  - Reads capture `sram_din` on the last cycle.
  - State then moves to RESP.
- Store lanes:
  - SW: all lanes.
  - SH: lanes {2·addr[1]+1, 2·addr[1]}, with the half-word replicated into both halves of `sram_dout`.
  - SB: lane addr[1:0], with the byte replicated into all four lanes.
- Load extract:
  - Select the lane(s) given by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- UART accesses:
  - UART_STAT read returns {30'b0, `uart_rx_valid`, ~`uart_tx_busy`}.
  - UART_DATA read returns {24'b0, `uart_rx_data`} and pulses `uart_rx_ack` in the RESP cycle, but only if `uart_rx_valid`=1.
  - UART_STAT write is ignored.
  - In UART_WAIT, the state holds while `uart_tx_busy`=1. Once it is 0, `uart_tx_valid` pulses one cycle with `uart_tx_data`=`wdata[7:0]`, then state → RESP.
- RESP: `io_ready`=1 for one cycle, `io_rdata` is stable, strobes are deasserted, then state → IDLE.
- `io_rdata` holds its value until the next load completes. Stores leave it unchanged.

## Timing
- Reset values (and the values in IDLE with no request):
  - `io_ready`=0, `io_rdata`=0.
  - `sram_ce_n`/`oe_n`/`we_n`=1, `sram_be_n`=1111, `sram_doe`=0.
  - `sram_addr`=0, `sram_dout`=0.
  - `uart_tx_valid`=0, `uart_rx_ack`=0, `uart_tx_data`=0.
  - State = IDLE.
- Request handshake:
  - The request is presented in cycle 0.
  - The requester holds it stable until the cycle in which `io_ready`=1.
  - The controller ignores `io_*` inputs between the latch and RESP.
- Latency from request to `io_ready`:
  - SRAM access: `WAIT_CYCLES`+1 cycles.
  - UART_STAT, UART_DATA read, unmapped/misaligned: 1 cycle.
  - UART_DATA write: 2 cycles plus the busy wait.
- Back-to-back requests: a request presented in the cycle after RESP is latched in that cycle. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- Write hold: `sram_addr`, `sram_dout` and `sram_be_n` are stable for the whole SRAM state. `sram_we_n` rises in RESP while `sram_dout` is still driven, giving hold time.
- Reset asserted mid-access: all outputs return to reset values on the next edge. No `io_ready` is produced and no UART strobe is issued.
- Simultaneous `uart_rx_valid` rise and a UART_DATA read: the sampled value in the latch cycle decides both the returned data and whether `uart_rx_ack` pulses.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` 2 cycles, then hold `io_mode`=NOP for 10 cycles.
  - Required: all outputs stay at reset values; `sram_ce_n` is never 0.
- SW then LW:
  - Stimulus: with `WAIT_CYCLES`=2, SW of 32'hDEADBEEF to 0x8000_0010, then LW from 0x8000_0010.
  - Required: `sram_addr`=4 and `sram_we_n`=0 for 2 cycles; `io_ready` in cycle 3 of each access; LW returns 32'hDEADBEEF.
- Sub-word loads and stores:
  - Stimulus: SB 8'h80 to 0x8000_0003, then load the same address as LB, LBU and LH (address 0x8000_0002).
  - Required: SB gives `sram_be_n`=0111 and `sram_dout`=32'h80808080. LB returns 32'hFFFFFF80, LBU returns 32'h00000080, LH returns 32'hFFFF80xx, sign-extended from the stored half-word.
- UART:
  - Stimulus 1: read UART_STAT with `uart_tx_busy`=0 and `uart_rx_valid`=1.
  - Required: returns 32'h3.
  - Stimulus 2: read UART_DATA with `uart_rx_data`=8'h41.
  - Required: returns 32'h41 and `uart_rx_ack` pulses exactly once.
  - Stimulus 3: SW of 8'h5A to UART_DATA while `uart_tx_busy`=1 for 5 cycles.
  - Required: `uart_tx_valid` pulses exactly once, in the cycle after busy falls, with data 8'h5A; `io_ready` follows one cycle later.
- Faults:
  - Stimulus: LW at 0x8000_0002; SW to 0x1000_0000.
  - Required: each gives `io_ready` after 1 cycle with `io_rdata`=0; the SRAM strobes and UART strobes never assert.
- Reset mid-access:
  - Stimulus: assert `rst` during SRAM-state cycle 1 of a SW.
  - Required: `sram_we_n`=1 on the next edge, no `io_ready` pulse, and state = IDLE.

Source files
------------

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: bridges the CPU's word-addressed IO port to an asynchronous
// 32-bit SRAM and to the UART registers.
//   clk, rst                 - clock, synchronous active-high reset
//   io_mode/io_addr/io_wdata - request (NOP,LW,LH,LHU,LB,LBU,SW,SH,SB)
//   io_rdata, io_ready       - registered load result, one-cycle completion
//   sram_*                   - SRAM address/data/strobes (strobes active-low)
//   uart_tx_*, uart_rx_*     - UART transmit strobe/data, receive pop
module io_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
  parameter logic [31:0] UART_DATA   = 32'hBFD0_03F8,
  parameter logic [31:0] UART_STAT   = 32'hBFD0_03FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_mode,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_ready,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_dout,
  input  logic [31:0] sram_din,
  output logic        sram_doe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ack
);

  localparam logic [3:0] MODE_LW  = 4'd1;
  localparam logic [3:0] MODE_LH  = 4'd2;
  localparam logic [3:0] MODE_LHU = 4'd3;
  localparam logic [3:0] MODE_LB  = 4'd4;
  localparam logic [3:0] MODE_LBU = 4'd5;
  localparam logic [3:0] MODE_SW  = 4'd6;
  localparam logic [3:0] MODE_SH  = 4'd7;
  localparam logic [3:0] MODE_SB  = 4'd8;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SRAM, UART_WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  mode_q;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt;
  logic        ram_acc;
  logic        ack_pend;
  logic [31:0] rdata_q;

  logic req, is_load, is_store, aligned, ram_go, uart_data_hit, uart_stat_hit;
  logic q_store;
  logic [3:0]  st_be;
  logic [31:0] st_dout;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Incoming request decode (only meaningful in IDLE)
  always_comb begin
    req      = (io_mode >= MODE_LW) && (io_mode <= MODE_SB);
    is_load  = (io_mode >= MODE_LW) && (io_mode <= MODE_LBU);
    is_store = (io_mode >= MODE_SW) && (io_mode <= MODE_SB);
    aligned  = 1'b1;
    if (io_mode == MODE_LW || io_mode == MODE_SW)
      aligned = (io_addr[1:0] == 2'b00);
    else if (io_mode == MODE_LH || io_mode == MODE_LHU || io_mode == MODE_SH)
      aligned = !io_addr[0];
    ram_go        = (io_addr[31:22] == RAM_BASE[31:22]) && aligned;
    uart_data_hit = (io_addr == UART_DATA);
    uart_stat_hit = (io_addr == UART_STAT);
  end

  // Store lane selection from the latched request; sub-words are replicated
  // so the SRAM sees the right byte whichever lane is enabled.
  assign q_store = (mode_q >= MODE_SW);

  always_comb begin
    st_be   = 4'b0000;
    st_dout = wdata_q;
    case (mode_q)
      MODE_SH: begin
        st_be   = addr_q[1] ? 4'b0011 : 4'b1100;
        st_dout = {2{wdata_q[15:0]}};
      end
      MODE_SB: begin
        st_be   = ~(4'b0001 << addr_q[1:0]);
        st_dout = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = sram_din[7:0];
      2'd1:    byte_sel = sram_din[15:8];
      2'd2:    byte_sel = sram_din[23:16];
      default: byte_sel = sram_din[31:24];
    endcase
    half_sel = addr_q[1] ? sram_din[31:16] : sram_din[15:0];
    case (mode_q)
      MODE_LH:  load_ext = {{16{half_sel[15]}}, half_sel};
      MODE_LHU: load_ext = {16'h0000, half_sel};
      MODE_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      MODE_LBU: load_ext = {24'h000000, byte_sel};
      default:  load_ext = sram_din;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (ram_go)                        state_nxt = SRAM;
          else if (uart_data_hit && is_store) state_nxt = UART_WAIT;
          else                               state_nxt = RESP;
        end
      end
      SRAM:      if (cnt == LAST_CNT) state_nxt = RESP;
      UART_WAIT: if (!uart_tx_busy)   state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      ram_acc  <= 1'b0;
      ack_pend <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            mode_q   <= io_mode;
            addr_q   <= io_addr[21:0];
            wdata_q  <= io_wdata;
            cnt      <= '0;
            ram_acc  <= ram_go;
            // UART status/data are sampled here, so the value returned and
            // the rx pop always agree even if uart_rx_valid changes later.
            ack_pend <= is_load && !ram_go && uart_data_hit && uart_rx_valid;
            if (is_load && !ram_go) begin
              if (uart_stat_hit)      rdata_q <= {30'b0, uart_rx_valid, ~uart_tx_busy};
              else if (uart_data_hit) rdata_q <= {24'b0, uart_rx_data};
              else                    rdata_q <= '0;
            end
          end
        end
        SRAM: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT && !q_store) rdata_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io_ready      = 1'b0;
    sram_addr     = '0;
    sram_dout     = '0;
    sram_doe      = 1'b0;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    sram_be_n     = '1;
    uart_tx_data  = '0;
    uart_tx_valid = 1'b0;
    uart_rx_ack   = 1'b0;
    case (state)
      SRAM: begin
        sram_addr = addr_q[21:2];
        sram_ce_n = 1'b0;
        if (q_store) begin
          sram_we_n = 1'b0;
          sram_doe  = 1'b1;
          sram_be_n = st_be;
          sram_dout = st_dout;
        end else begin
          sram_oe_n = 1'b0;
          sram_be_n = '0;
        end
      end
      UART_WAIT: begin
        uart_tx_data  = wdata_q[7:0];
        uart_tx_valid = !uart_tx_busy;
      end
      RESP: begin
        io_ready    = 1'b1;
        uart_rx_ack = ack_pend;
        // Keep address and data driven one cycle past the we_n rise (hold time)
        if (ram_acc && q_store) begin
          sram_addr = addr_q[21:2];
          sram_dout = st_dout;
          sram_doe  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io_rdata = rdata_q;

endmodule
